// File: rtl/pcpi_vec_mem_arbiter.sv
// ---------------------------------------------------------------------------
// pcpi_vec_mem_arbiter
//
// Shares one single-ported memory between the picorv32 CPU memory port and
// the picorv32_pcpi_vec memory port. Round-robin arbitration, one transaction
// at a time, all downstream and upstream outputs registered.
//
// Sequence per transaction: IDLE (grant) -> BUSY (wait mem_ready) -> RESP
// (one-cycle ready pulse to the grantee) -> IDLE. The RESP cycle is a bubble
// that lets the served requester drop its valid before inputs are sampled
// again, and guarantees mem_valid falls the cycle after mem_ready.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   cpu_mem_valid/instr/addr/wdata/wstrb   CPU request (held until ready)
//   cpu_mem_ready, cpu_mem_rdata           CPU completion pulse and read data
//   vec_mem_valid/addr/wdata/wstrb         vector unit request
//   vec_mem_ready, vec_mem_rdata           vector completion pulse and data
//   mem_valid/instr/addr/wdata/wstrb       downstream request (registered)
//   mem_ready, mem_rdata                   downstream completion and data
//   gnt_vec                     1 while the vector unit owns the memory
//
// Optional feature (macro PCPI_VEC_ARB_BURST_EN): on a tie the vector unit
// keeps the memory for up to VEC_BURST_MAX consecutive grants. Without the
// macro the arbiter alternates strictly on ties.
// ---------------------------------------------------------------------------
module pcpi_vec_mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int VEC_BURST_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cpu_mem_valid,
  input  logic                cpu_mem_instr,
  input  logic [ADDR_W-1:0]   cpu_mem_addr,
  input  logic [DATA_W-1:0]   cpu_mem_wdata,
  input  logic [DATA_W/8-1:0] cpu_mem_wstrb,
  output logic                cpu_mem_ready,
  output logic [DATA_W-1:0]   cpu_mem_rdata,
  input  logic                vec_mem_valid,
  input  logic [ADDR_W-1:0]   vec_mem_addr,
  input  logic [DATA_W-1:0]   vec_mem_wdata,
  input  logic [DATA_W/8-1:0] vec_mem_wstrb,
  output logic                vec_mem_ready,
  output logic [DATA_W-1:0]   vec_mem_rdata,
  output logic                mem_valid,
  output logic                mem_instr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                gnt_vec
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Reject burst limits the 4-bit burst counter cannot represent.
  if (VEC_BURST_MAX < 1 || VEC_BURST_MAX > 15) begin : g_bad_burst_max
    $error("VEC_BURST_MAX must be in 1..15");
  end

  state_t              state_q;
  logic                rr_last_q;     // last grantee: 1 = VEC, 0 = CPU
  logic                mem_valid_q;
  logic                mem_instr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_wstrb_q;
  logic                gnt_vec_q;
  logic                cpu_ready_q;
  logic                vec_ready_q;
  logic [DATA_W-1:0]   cpu_rdata_q;
  logic [DATA_W-1:0]   vec_rdata_q;

  logic                req_any_s;
  logic                pick_vec_s;

  assign req_any_s = cpu_mem_valid | vec_mem_valid;

`ifdef PCPI_VEC_ARB_BURST_EN
  localparam logic [3:0] BURST_LIMIT = 4'(VEC_BURST_MAX - 1);

  // vec_prev_q marks that the previous grant really went to VEC. It differs
  // from rr_last_q only after reset, where rr_last_q=VEC but no VEC grant has
  // happened yet, so the CPU still wins the first tie.
  logic [3:0] burst_cnt_q;
  logic       vec_prev_q;
  logic       grant_s;

  assign grant_s = (state_q == ST_IDLE) && req_any_s;

  // Count consecutive VEC grants; any CPU grant restarts the run.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      burst_cnt_q <= 4'd0;
      vec_prev_q  <= 1'b0;
    end else if (grant_s) begin
      vec_prev_q <= pick_vec_s;
      if (pick_vec_s && vec_prev_q) begin
        burst_cnt_q <= (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_q <= 4'd0;
      end
    end else begin
      burst_cnt_q <= burst_cnt_q;
      vec_prev_q  <= vec_prev_q;
    end
  end
`endif

  // Arbitration decision, only acted upon in IDLE.
  always_comb begin
    pick_vec_s = 1'b0;
    if (cpu_mem_valid && vec_mem_valid) begin
`ifdef PCPI_VEC_ARB_BURST_EN
      pick_vec_s = (vec_prev_q && (burst_cnt_q < BURST_LIMIT)) ? 1'b1 : ~rr_last_q;
`else
      pick_vec_s = ~rr_last_q;
`endif
    end else begin
      pick_vec_s = vec_mem_valid;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      rr_last_q   <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_instr_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      gnt_vec_q   <= 1'b0;
      cpu_ready_q <= 1'b0;
      vec_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      vec_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cpu_ready_q <= 1'b0;
          vec_ready_q <= 1'b0;
          if (req_any_s) begin
            mem_valid_q <= 1'b1;
            mem_instr_q <= pick_vec_s ? 1'b0 : cpu_mem_instr;
            mem_addr_q  <= pick_vec_s ? vec_mem_addr  : cpu_mem_addr;
            mem_wdata_q <= pick_vec_s ? vec_mem_wdata : cpu_mem_wdata;
            mem_wstrb_q <= pick_vec_s ? vec_mem_wstrb : cpu_mem_wstrb;
            gnt_vec_q   <= pick_vec_s;
            rr_last_q   <= pick_vec_s;
            state_q     <= ST_BUSY;
          end else begin
            gnt_vec_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (gnt_vec_q) begin
              vec_rdata_q <= mem_rdata;
              vec_ready_q <= 1'b1;
            end else begin
              cpu_rdata_q <= mem_rdata;
              cpu_ready_q <= 1'b1;
            end
            state_q <= ST_RESP;
          end else begin
            state_q <= ST_BUSY;
          end
        end
        ST_RESP: begin
          // Always return to IDLE: never re-grant straight out of RESP.
          cpu_ready_q <= 1'b0;
          vec_ready_q <= 1'b0;
          gnt_vec_q   <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_valid_q <= 1'b0;
          gnt_vec_q   <= 1'b0;
          cpu_ready_q <= 1'b0;
          vec_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_valid     = mem_valid_q;
  assign mem_instr     = mem_instr_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign gnt_vec       = gnt_vec_q;
  assign cpu_mem_ready = cpu_ready_q;
  assign cpu_mem_rdata = cpu_rdata_q;
  assign vec_mem_ready = vec_ready_q;
  assign vec_mem_rdata = vec_rdata_q;

endmodule

// File: tb/tb_pcpi_vec_mem_arbiter.sv
module tb_pcpi_vec_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_valid, cpu_instr;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        vec_valid;
  logic [31:0] vec_addr, vec_wdata;
  logic [3:0]  vec_wstrb;
  logic        cpu_mem_ready, vec_mem_ready;
  logic [31:0] cpu_mem_rdata, vec_mem_rdata;
  logic        mem_valid, mem_instr, gnt_vec;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_ready_q, spur_ready;
  logic [31:0] mem_rdata_q;
  logic [31:0] mem_arr [0:255];

  always #5 clk = ~clk;

  pcpi_vec_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .VEC_BURST_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_mem_valid(cpu_valid), .cpu_mem_instr(cpu_instr), .cpu_mem_addr(cpu_addr),
    .cpu_mem_wdata(cpu_wdata), .cpu_mem_wstrb(cpu_wstrb),
    .cpu_mem_ready(cpu_mem_ready), .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_valid), .vec_mem_addr(vec_addr), .vec_mem_wdata(vec_wdata),
    .vec_mem_wstrb(vec_wstrb), .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata_q), .gnt_vec(gnt_vec)
  );

  // One-cycle memory: ready one cycle after valid, single pulse; rdata is the
  // word before any write in the same access.
  assign mem_ready = mem_ready_q | spur_ready;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready_q <= 1'b0;
      mem_rdata_q <= 32'h0;
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'hA500_0000 | 32'(i);
      mem_arr[0]   <= 32'h0040_0113;
      mem_arr[100] <= 32'h0403_0201;
      mem_arr[104] <= 32'h1413_1211;
    end else begin
      mem_ready_q <= 1'b0;
      if (mem_valid && !mem_ready_q) begin
        mem_ready_q <= 1'b1;
        mem_rdata_q <= mem_arr[mem_addr[9:2]];
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) mem_arr[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct { bit is_vec; logic [31:0] rdata; } sb_t;
  sb_t exp_q[$];

  task automatic sb_push(input bit is_vec, input logic [31:0] rdata);
    sb_t e;
    e.is_vec = is_vec;
    e.rdata  = rdata;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input bit act_vec, input logic [31:0] act_rdata);
    sb_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_unexpected: ready from vec=%0d, expected no response", act_vec);
    end else begin
      e = exp_q.pop_front();
      chk("sb_grantee_is_vec", 32'(act_vec), 32'(e.is_vec));
      chk("sb_rdata", act_rdata, e.rdata);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({name, "_gnt_vec"}, 32'(gnt_vec), 32'd0);
    chk({name, "_cpu_ready"}, 32'(cpu_mem_ready), 32'd0);
    chk({name, "_vec_ready"}, 32'(vec_mem_ready), 32'd0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cpu_valid = 1'b0;
    vec_valid = 1'b0;
    #1 chk_quiet("rst_async");
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Runs until n ready pulses are seen (bounded). drop=1: a served requester
  // drops valid in its ready cycle; drop=0: both stay valid throughout.
  task automatic run_grants(input int n, input bit drop, input int budget);
    int  seen = 0;
    int  cyc = 0;
    bit  prev_rdy = 1'b0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cpu_mem_ready || vec_mem_ready) begin
        chk("ready_onehot", 32'(cpu_mem_ready & vec_mem_ready), 32'd0);
        sb_pop(vec_mem_ready, vec_mem_ready ? vec_mem_rdata : cpu_mem_rdata);
        chk("resp_mem_valid", 32'(mem_valid), 32'd0);
        chk("resp_gnt_vec", 32'(gnt_vec), 32'(vec_mem_ready));
        if (drop) begin
          if (cpu_mem_ready) cpu_valid = 1'b0;
          if (vec_mem_ready) vec_valid = 1'b0;
        end
        seen++;
        prev_rdy = 1'b1;
      end else begin
        if (prev_rdy) begin
          chk("idle_mem_valid", 32'(mem_valid), 32'd0);
          chk("idle_gnt_vec", 32'(gnt_vec), 32'd0);
        end
        prev_rdy = 1'b0;
      end
    end
    if (seen < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_grants_timeout: got %0d ready pulses, expected %0d", seen, n);
    end
    cpu_valid = 1'b0;
    vec_valid = 1'b0;
  endtask

  typedef struct {
    bit          is_vec;
    bit          instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        exp_instr;
    logic [31:0] exp_rdata;
  } vec_t;

  // Single-requester transaction with exact cycle-by-cycle checks.
  task automatic single_txn(input vec_t r);
    if (r.is_vec) begin
      vec_valid = 1'b1; vec_addr = r.addr; vec_wdata = r.wdata; vec_wstrb = r.wstrb;
    end else begin
      cpu_valid = 1'b1; cpu_instr = r.instr; cpu_addr = r.addr;
      cpu_wdata = r.wdata; cpu_wstrb = r.wstrb;
    end
    sb_push(r.is_vec, r.exp_rdata);
    @(negedge clk);
    chk("n1_mem_valid", 32'(mem_valid), 32'd1);
    chk("n1_mem_addr", mem_addr, r.addr);
    chk("n1_mem_wdata", mem_wdata, r.wdata);
    chk("n1_mem_wstrb", 32'(mem_wstrb), 32'(r.wstrb));
    chk("n1_mem_instr", 32'(mem_instr), 32'(r.exp_instr));
    chk("n1_gnt_vec", 32'(gnt_vec), 32'(r.is_vec));
    @(negedge clk);
    chk("n2_mem_valid", 32'(mem_valid), 32'd1);
    chk("n2_no_ready", 32'(cpu_mem_ready | vec_mem_ready), 32'd0);
    @(negedge clk);
    chk("n3_cpu_ready", 32'(cpu_mem_ready), 32'(!r.is_vec));
    chk("n3_vec_ready", 32'(vec_mem_ready), 32'(r.is_vec));
    chk("n3_mem_valid", 32'(mem_valid), 32'd0);
    if (cpu_mem_ready || vec_mem_ready)
      sb_pop(vec_mem_ready, vec_mem_ready ? vec_mem_rdata : cpu_mem_rdata);
    cpu_valid = 1'b0;
    vec_valid = 1'b0;
    @(negedge clk);
    chk("n4_no_ready", 32'(cpu_mem_ready | vec_mem_ready), 32'd0);
    chk("n4_mem_valid", 32'(mem_valid), 32'd0);
    chk("n4_rdata_hold", r.is_vec ? vec_mem_rdata : cpu_mem_rdata, r.exp_rdata);
  endtask

  vec_t tbl [6];
  bit   ord_cont  [8];
  bit   ord_burst [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    int hits;
    // {is_vec, instr, addr, wdata, wstrb, exp_instr, exp_rdata}
    tbl[0] = '{1'b0, 1'b1, 32'h000, 32'h0,         4'b0000, 1'b1, 32'h0040_0113};
    tbl[1] = '{1'b1, 1'b0, 32'h190, 32'h0,         4'b0000, 1'b0, 32'h0403_0201};
    tbl[2] = '{1'b1, 1'b0, 32'h1A0, 32'hAABB_CCDD, 4'b0011, 1'b0, 32'h1413_1211};
    tbl[3] = '{1'b0, 1'b0, 32'h008, 32'h1234_5678, 4'b1111, 1'b0, 32'hA500_0002};
    tbl[4] = '{1'b0, 1'b0, 32'h1A0, 32'h0,         4'b0000, 1'b0, 32'h1413_CCDD};
    tbl[5] = '{1'b1, 1'b0, 32'h3FC, 32'h0,         4'b0000, 1'b0, 32'hA500_00FF};
`ifdef PCPI_VEC_ARB_BURST_EN
    ord_cont  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ord_burst = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    ord_cont  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ord_burst = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    cpu_valid = 1'b0; cpu_instr = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_wstrb = 4'h0;
    vec_valid = 1'b0; vec_addr = 32'h0; vec_wdata = 32'h0; vec_wstrb = 4'h0;
    spur_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk("reset_mem_instr", 32'(mem_instr), 32'h0);
    chk("reset_cpu_rdata", cpu_mem_rdata, 32'h0);
    chk("reset_vec_rdata", vec_mem_rdata, 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Tie straight out of reset: CPU first, then VEC.
    cpu_valid = 1'b1; cpu_addr = 32'h004; cpu_wstrb = 4'h0;
    vec_valid = 1'b1; vec_addr = 32'h190; vec_wstrb = 4'h0;
    sb_push(1'b0, 32'hA500_0001);
    sb_push(1'b1, 32'h0403_0201);
    run_grants(2, 1'b1, 40);
    @(negedge clk);

    // Table of single-requester transactions.
    for (int i = 0; i < 6; i++) single_txn(tbl[i]);
    chk("mem104_after_write", mem_arr[104], 32'h1413_CCDD);
    chk("mem2_after_write", mem_arr[2], 32'h1234_5678);

    // Inputs changed during BUSY are ignored; a valid that drops before
    // IDLE is never granted; mem_ready outside BUSY is ignored.
    cpu_valid = 1'b1; cpu_instr = 1'b0; cpu_addr = 32'h010; cpu_wstrb = 4'h0;
    sb_push(1'b0, 32'hA500_0004);
    @(negedge clk);
    chk("busy_addr_n1", mem_addr, 32'h010);
    cpu_addr = 32'h3FC;
    vec_valid = 1'b1; vec_addr = 32'h020;
    @(negedge clk);
    vec_valid = 1'b0;
    chk("busy_addr_held", mem_addr, 32'h010);
    chk("busy_gnt_cpu", 32'(gnt_vec), 32'd0);
    @(negedge clk);
    chk("busy_cpu_ready", 32'(cpu_mem_ready), 32'd1);
    if (cpu_mem_ready) sb_pop(1'b0, cpu_mem_rdata);
    cpu_valid = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      spur_ready = (i == 1);
      @(negedge clk);
      if (mem_valid || cpu_mem_ready || vec_mem_ready || gnt_vec) hits++;
    end
    spur_ready = 1'b0;
    chk("no_grant_no_spurious_ack", 32'(hits), 32'd0);

    // Continuous contention from reset.
    do_reset();
    @(negedge clk);
    cpu_valid = 1'b1; cpu_addr = 32'h010; cpu_wstrb = 4'h0;
    vec_valid = 1'b1; vec_addr = 32'h020; vec_wstrb = 4'h0;
    for (int i = 0; i < 8; i++) sb_push(ord_cont[i], ord_cont[i] ? 32'hA500_0008 : 32'hA500_0004);
    run_grants(8, 1'b0, 100);
    @(negedge clk);

    // VEC alone for the first grant, then contention.
    do_reset();
    @(negedge clk);
    vec_valid = 1'b1; vec_addr = 32'h020; vec_wstrb = 4'h0;
    hits = 0;
    for (int i = 0; i < 10 && !mem_valid; i++) begin
      @(negedge clk);
      hits++;
    end
    chk("burst_first_grant_seen", 32'(mem_valid), 32'd1);
    cpu_valid = 1'b1; cpu_addr = 32'h010; cpu_wstrb = 4'h0;
    for (int i = 0; i < 8; i++) sb_push(ord_burst[i], ord_burst[i] ? 32'hA500_0008 : 32'hA500_0004);
    run_grants(8, 1'b0, 100);
    @(negedge clk);

    // Asynchronous reset in BUSY abandons the transaction.
    vec_valid = 1'b1; vec_addr = 32'h190; vec_wstrb = 4'h0;
    @(negedge clk);
    chk("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    chk("pre_rst_gnt_vec", 32'(gnt_vec), 32'd1);
    #2;
    do_reset();
    @(negedge clk);
    chk_quiet("post_rst_idle");
    cpu_valid = 1'b1; cpu_addr = 32'h004; cpu_wstrb = 4'h0;
    vec_valid = 1'b1; vec_addr = 32'h190; vec_wstrb = 4'h0;
    sb_push(1'b0, 32'hA500_0001);
    sb_push(1'b1, 32'h0403_0201);
    run_grants(2, 1'b1, 40);

    chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
